// File: rtl/yarp_mem_arbiter.sv
// Two-requester (instruction fetch / data access) arbiter onto one single-port memory.
// Define YARP_MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority.
module yarp_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        imem_req_i,
    input  logic [31:0] imem_addr_i,
    output logic        imem_gnt_o,
    output logic        imem_rvalid_o,
    output logic [31:0] imem_rdata_o,

    input  logic        dmem_req_i,
    input  logic [31:0] dmem_addr_i,
    input  logic        dmem_wr_i,
    input  logic [1:0]  dmem_byte_en_i,
    input  logic [31:0] dmem_wdata_i,
    output logic        dmem_gnt_o,
    output logic        dmem_rvalid_o,
    output logic [31:0] dmem_rdata_o,

    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_wr_o,
    output logic [1:0]  mem_byte_en_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        err_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;      // 1 = data requester owns the transaction
    logic        mem_req_q, mem_req_d;
    logic [31:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [1:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] wdog_q, wdog_d;
    logic        pick_data;
    logic        expire;

`ifdef YARP_MEM_ARB_RR_EN
    logic        rr_q, rr_d;            // last granted requester, 1 = data

    // On a tie the requester that was not granted last wins.
    assign pick_data = dmem_req_i && (!imem_req_i || !rr_q);
`else
    assign pick_data = dmem_req_i;
`endif

    assign expire = (TIMEOUT_CYC != 0) && (wdog_q == TIMEOUT_CYC - 1);

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        wr_d          = wr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        wdog_d        = wdog_q;
`ifdef YARP_MEM_ARB_RR_EN
        rr_d          = rr_q;
`endif
        imem_gnt_o    = 1'b0;
        imem_rvalid_o = 1'b0;
        imem_rdata_o  = 32'h0;
        dmem_gnt_o    = 1'b0;
        dmem_rvalid_o = 1'b0;
        dmem_rdata_o  = 32'h0;
        err_o         = 1'b0;

        case (state_q)
            StIdle: begin
                if (imem_req_i || dmem_req_i) begin
                    owner_d = pick_data;
`ifdef YARP_MEM_ARB_RR_EN
                    rr_d    = pick_data;
`endif
                    if (pick_data) begin
                        addr_d  = dmem_addr_i;
                        wr_d    = dmem_wr_i;
                        be_d    = dmem_byte_en_i;
                        wdata_d = dmem_wdata_i;
                    end else begin
                        addr_d  = imem_addr_i;
                        wr_d    = 1'b0;
                        be_d    = 2'b11;
                        wdata_d = 32'h0;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (mem_gnt_i) begin
                    imem_gnt_o = !owner_q;
                    dmem_gnt_o = owner_q;
                    wdog_d     = 32'h0;
                    state_d    = StWait;
                end
            end
            StWait: begin
                wdog_d = wdog_q + 32'd1;
                // A real response takes precedence over a simultaneous watchdog expiry.
                if (mem_rvalid_i) begin
                    imem_rvalid_o = !owner_q;
                    dmem_rvalid_o = owner_q;
                    imem_rdata_o  = owner_q ? 32'h0 : mem_rdata_i;
                    dmem_rdata_o  = (owner_q && !wr_q) ? mem_rdata_i : 32'h0;
                    state_d       = StIdle;
                end else if (expire) begin
                    imem_rvalid_o = !owner_q;
                    dmem_rvalid_o = owner_q;
                    err_o         = 1'b1;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        mem_req_d = (state_d == StIssue);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            mem_req_q <= 1'b0;
            addr_q    <= 32'h0;
            wr_q      <= 1'b0;
            be_q      <= 2'b00;
            wdata_q   <= 32'h0;
            wdog_q    <= 32'h0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            mem_req_q <= mem_req_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            wdog_q    <= wdog_d;
        end
    end

`ifdef YARP_MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = addr_q;
    assign mem_wr_o      = wr_q;
    assign mem_byte_en_o = be_q;
    assign mem_wdata_o   = wdata_q;
    assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// Directed bench for yarp_mem_arbiter with a 4-cycle watchdog.
module tb_yarp_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        imem_req_i;
    logic [31:0] imem_addr_i;
    logic        imem_gnt_o;
    logic        imem_rvalid_o;
    logic [31:0] imem_rdata_o;
    logic        dmem_req_i;
    logic [31:0] dmem_addr_i;
    logic        dmem_wr_i;
    logic [1:0]  dmem_byte_en_i;
    logic [31:0] dmem_wdata_i;
    logic        dmem_gnt_o;
    logic        dmem_rvalid_o;
    logic [31:0] dmem_rdata_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic        mem_wr_o;
    logic [1:0]  mem_byte_en_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;
    logic        busy_o;

    int n_tests;
    int n_fail;

    yarp_mem_arbiter #(
        .TIMEOUT_CYC(4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_i     (imem_req_i),
        .imem_addr_i    (imem_addr_i),
        .imem_gnt_o     (imem_gnt_o),
        .imem_rvalid_o  (imem_rvalid_o),
        .imem_rdata_o   (imem_rdata_o),
        .dmem_req_i     (dmem_req_i),
        .dmem_addr_i    (dmem_addr_i),
        .dmem_wr_i      (dmem_wr_i),
        .dmem_byte_en_i (dmem_byte_en_i),
        .dmem_wdata_i   (dmem_wdata_i),
        .dmem_gnt_o     (dmem_gnt_o),
        .dmem_rvalid_o  (dmem_rvalid_o),
        .dmem_rdata_o   (dmem_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_addr_o     (mem_addr_o),
        .mem_wr_o       (mem_wr_o),
        .mem_byte_en_o  (mem_byte_en_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .err_o          (err_o),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge, where outputs are sampled.
    task automatic settle();
        #4;
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        imem_req_i     = 1'b0;
        imem_addr_i    = 32'h0;
        dmem_req_i     = 1'b0;
        dmem_addr_i    = 32'h0;
        dmem_wr_i      = 1'b0;
        dmem_byte_en_i = 2'b00;
        dmem_wdata_i   = 32'h0;
        mem_gnt_i      = 1'b0;
        mem_rvalid_i   = 1'b0;
        mem_rdata_i    = 32'h0;
        #12;
        n_tests++;
        if ({busy_o, mem_req_o, err_o, imem_gnt_o, dmem_gnt_o, imem_rvalid_o, dmem_rvalid_o}
            !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0", {busy_o, mem_req_o, err_o, imem_gnt_o,
                     dmem_gnt_o, imem_rvalid_o, dmem_rvalid_o});
        end
        n_tests++;
        if ({mem_addr_o, mem_wdata_o, mem_wr_o, mem_byte_en_o} !== 67'h0) begin
            n_fail++;
            $display("FAIL reset_payload: got addr %h wdata %h want 0", mem_addr_o, mem_wdata_o);
        end
        #11 reset_n = 1'b1;
    endtask

    task automatic test_single_instr();
        tick();
        imem_req_i  = 1'b1;
        imem_addr_i = 32'h1000;
        mem_gnt_i   = 1'b1;
        settle();
        n_tests++;
        if (mem_req_o !== 1'b0 || imem_gnt_o !== 1'b0) begin
            n_fail++;
            $display("FAIL instr_c0: got req %b gnt %b want 0 0", mem_req_o, imem_gnt_o);
        end
        tick();
        settle();
        n_tests++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h1000 || imem_gnt_o !== 1'b1 ||
            dmem_gnt_o !== 1'b0 || mem_wr_o !== 1'b0) begin
            n_fail++;
            $display("FAIL instr_c1: got req %b addr %h igi %b dg %b wr %b want 1 1000 1 0 0",
                     mem_req_o, mem_addr_o, imem_gnt_o, dmem_gnt_o, mem_wr_o);
        end
        tick();
        imem_req_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h00500093;
        settle();
        n_tests++;
        if (imem_rvalid_o !== 1'b1 || imem_rdata_o !== 32'h00500093 ||
            dmem_rvalid_o !== 1'b0 || dmem_rdata_o !== 32'h0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL instr_c2: got iv %b id %h dv %b dd %h want 1 00500093 0 0",
                     imem_rvalid_o, imem_rdata_o, dmem_rvalid_o, dmem_rdata_o);
        end
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        n_tests++;
        if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL instr_c3: got busy %b req %b want 0 0", busy_o, mem_req_o);
        end
    endtask

    task automatic test_priority();
        tick();
        imem_req_i     = 1'b1;
        imem_addr_i    = 32'h1004;
        dmem_req_i     = 1'b1;
        dmem_addr_i    = 32'h2000;
        dmem_wr_i      = 1'b1;
        dmem_byte_en_i = 2'b11;
        dmem_wdata_i   = 32'hdeadbeef;
        mem_gnt_i      = 1'b0;
        tick();
        mem_gnt_i = 1'b1;
        settle();
        n_tests++;
        if (mem_addr_o !== 32'h2000 || mem_wr_o !== 1'b1 || mem_wdata_o !== 32'hdeadbeef ||
            mem_byte_en_o !== 2'b11 || dmem_gnt_o !== 1'b1 || imem_gnt_o !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_data_issue: got addr %h wr %b wd %h be %b dg %b ig %b",
                     mem_addr_o, mem_wr_o, mem_wdata_o, mem_byte_en_o, dmem_gnt_o, imem_gnt_o);
        end
        tick();
        dmem_req_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h12345678;
        settle();
        n_tests++;
        if (dmem_rvalid_o !== 1'b1 || dmem_rdata_o !== 32'h0 || imem_rvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_write_ack: got dv %b dd %h iv %b want 1 0 0",
                     dmem_rvalid_o, dmem_rdata_o, imem_rvalid_o);
        end
        tick();
        mem_rvalid_i = 1'b0;
        tick();
        mem_gnt_i = 1'b1;
        settle();
        n_tests++;
        if (mem_addr_o !== 32'h1004 || mem_wr_o !== 1'b0 || imem_gnt_o !== 1'b1 ||
            dmem_gnt_o !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_instr_issue: got addr %h wr %b ig %b dg %b want 1004 0 1 0",
                     mem_addr_o, mem_wr_o, imem_gnt_o, dmem_gnt_o);
        end
        tick();
        imem_req_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hcafef00d;
        settle();
        n_tests++;
        if (imem_rvalid_o !== 1'b1 || imem_rdata_o !== 32'hcafef00d || dmem_rvalid_o !== 1'b0)
        begin
            n_fail++;
            $display("FAIL prio_instr_resp: got iv %b id %h dv %b want 1 cafef00d 0",
                     imem_rvalid_o, imem_rdata_o, dmem_rvalid_o);
        end
        tick();
        mem_rvalid_i = 1'b0;
        dmem_wr_i    = 1'b0;
    endtask

    task automatic test_stall();
        int gnt_cnt;
        gnt_cnt = 0;
        tick();
        dmem_req_i     = 1'b1;
        dmem_addr_i    = 32'h3000;
        dmem_wr_i      = 1'b0;
        dmem_byte_en_i = 2'b01;
        mem_gnt_i      = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            settle();
            if (dmem_gnt_o === 1'b1) gnt_cnt++;
            n_tests++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h3000 || mem_byte_en_o !== 2'b01 ||
                mem_wr_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold c%0d: got req %b addr %h be %b wr %b", c, mem_req_o,
                         mem_addr_o, mem_byte_en_o, mem_wr_o);
            end
        end
        tick();
        mem_gnt_i = 1'b1;
        settle();
        if (dmem_gnt_o === 1'b1) gnt_cnt++;
        tick();
        dmem_req_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'ha5a5a5a5;
        settle();
        if (dmem_gnt_o === 1'b1) gnt_cnt++;
        n_tests++;
        if (gnt_cnt != 1) begin
            n_fail++;
            $display("FAIL stall_gnt_count: got %0d want 1", gnt_cnt);
        end
        n_tests++;
        if (dmem_rvalid_o !== 1'b1 || dmem_rdata_o !== 32'ha5a5a5a5) begin
            n_fail++;
            $display("FAIL stall_read_resp: got dv %b dd %h want 1 a5a5a5a5",
                     dmem_rvalid_o, dmem_rdata_o);
        end
        tick();
        mem_rvalid_i = 1'b0;
    endtask

    // Data read that gets no response for three WAIT cycles; on the fourth either
    // the watchdog fires alone or a response collides with it.
    task automatic test_watchdog(input logic collide);
        tick();
        dmem_req_i  = 1'b1;
        dmem_addr_i = 32'h4000;
        dmem_wr_i   = 1'b0;
        mem_gnt_i   = 1'b1;
        tick();
        tick();
        dmem_req_i  = 1'b0;
        mem_gnt_i   = 1'b0;
        mem_rdata_i = 32'hffffffff;
        for (int c = 1; c <= 3; c++) begin
            settle();
            n_tests++;
            if (err_o !== 1'b0 || dmem_rvalid_o !== 1'b0 || busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL wdog_quiet w%0d: got err %b dv %b busy %b want 0 0 1", c, err_o,
                         dmem_rvalid_o, busy_o);
            end
            tick();
        end
        if (collide) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'h13572468;
        end
        settle();
        n_tests++;
        if (collide) begin
            if (err_o !== 1'b0 || dmem_rvalid_o !== 1'b1 || dmem_rdata_o !== 32'h13572468) begin
                n_fail++;
                $display("FAIL wdog_collide: got err %b dv %b dd %h want 0 1 13572468",
                         err_o, dmem_rvalid_o, dmem_rdata_o);
            end
        end else begin
            if (err_o !== 1'b1 || dmem_rvalid_o !== 1'b1 || dmem_rdata_o !== 32'h0 ||
                imem_rvalid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL wdog_expire: got err %b dv %b dd %h iv %b want 1 1 0 0",
                         err_o, dmem_rvalid_o, dmem_rdata_o, imem_rvalid_o);
            end
        end
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        n_tests++;
        if (busy_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wdog_idle: got busy %b err %b want 0 0", busy_o, err_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        tick();
        imem_req_i  = 1'b1;
        imem_addr_i = 32'h5000;
        mem_gnt_i   = 1'b1;
        tick();
        tick();
        imem_req_i = 1'b0;
        mem_gnt_i  = 1'b0;
        settle();
        n_tests++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_busy: got %b want 1", busy_o);
        end
        #2;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0badf00d;
        reset_n      = 1'b0;
        #1;
        n_tests++;
        if ({busy_o, mem_req_o, imem_rvalid_o, dmem_rvalid_o, err_o} !== 5'b0 ||
            mem_addr_o !== 32'h0 || imem_rdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_wait: got busy %b req %b iv %b addr %h id %h want all 0",
                     busy_o, mem_req_o, imem_rvalid_o, mem_addr_o, imem_rdata_o);
        end
        mem_rvalid_i = 1'b0;
        #10 reset_n = 1'b1;
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h77777777;
        settle();
        n_tests++;
        if (imem_rvalid_o !== 1'b0 || dmem_rvalid_o !== 1'b0 || imem_rdata_o !== 32'h0 ||
            dmem_rdata_o !== 32'h0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_rvalid: got iv %b dv %b id %h dd %h busy %b want 0",
                     imem_rvalid_o, dmem_rvalid_o, imem_rdata_o, dmem_rdata_o, busy_o);
        end
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        n_tests++;
        if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_idle: got busy %b req %b want 0 0", busy_o, mem_req_o);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single_instr();
        test_priority();
        test_stall();
        test_watchdog(1'b0);
        test_watchdog(1'b1);
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/yarp_mem_arbiter.md
# yarp_mem_arbiter

Shares one unified single-port memory between the YARP core's instruction-fetch and data-access requesters. The block sits between the core's `instr_mem_*` / `data_mem_*` interfaces and a single external memory port. It arbitrates between the two, issues one transaction at a time, and routes each response back to the requester that owns it. A watchdog bounds every transaction, so a lost memory response cannot hang the core.

## Interface
- `TIMEOUT_CYC`, default 64: maximum cycles in WAIT before abort; 0 disables the watchdog.
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `imem_req_i` in 1: instruction read request.
- `imem_addr_i` in 32: instruction address.
- `imem_gnt_o` out 1: instruction request accepted by memory.
- `imem_rvalid_o` out 1: instruction read data valid.
- `imem_rdata_o` out 32: instruction read data.
- `dmem_req_i` in 1: data request.
- `dmem_addr_i` in 32: data address.
- `dmem_wr_i` in 1: 1 = write, 0 = read.
- `dmem_byte_en_i` in 2: access size, passed through unchanged.
- `dmem_wdata_i` in 32: write data.
- `dmem_gnt_o` out 1: data request accepted by memory.
- `dmem_rvalid_o` out 1: data response (read data or write ack).
- `dmem_rdata_o` out 32: data read data.
- `mem_req_o` out 1: memory request.
- `mem_gnt_i` in 1: memory accepts the request.
- `mem_addr_o` out 32: memory address.
- `mem_wr_o` out 1: memory write enable.
- `mem_byte_en_o` out 2: memory access size.
- `mem_wdata_o` out 32: memory write data.
- `mem_rvalid_i` in 1: memory response valid (reads and writes).
- `mem_rdata_i` in 32: memory read data.
- `err_o` out 1: one-cycle pulse on watchdog abort.
- `busy_o` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT. Only one transaction is outstanding at any time.
- **IDLE:**
  - If any request is high, pick the winner.
  - Latch the owner, address, write flag, byte enable and write data into registers.
  - Go to ISSUE.
- **ISSUE:**
  - `mem_req_o`=1 and all `mem_*` outputs are driven from the latched registers.
  - When `mem_gnt_i`=1, pulse the owner's `*_gnt_o` in that same cycle, then go to WAIT.
- **WAIT:**
  - On `mem_rvalid_i`=1, drive the owner's `*_rvalid_o`=1 combinationally. `*_rdata_o`=`mem_rdata_i`; the non-owner's rdata is 0.
  - Go to IDLE.
- **Watchdog:**
  - The counter clears on entering WAIT and increments each WAIT cycle.
  - When the count reaches `TIMEOUT_CYC`: pulse the owner's `*_rvalid_o` with rdata 0, pulse `err_o`, go to IDLE.
- **Requester rules:**
  - A requester holds req and all payload stable until its gnt.
  - A requester must not drop req before gnt. If it does, the latched transaction still completes and the response is still returned.
- `mem_rvalid_i` in IDLE or ISSUE is ignored; no rvalid is forwarded.
- A response and a watchdog expiry in the same cycle: the response wins and `err_o` stays 0.
- Write transactions complete on `mem_rvalid_i` (write ack); `dmem_rdata_o` is 0 for writes.

## Timing
- Reset: state IDLE, all outputs 0, latched registers 0, watchdog counter 0, RR pointer = instr.
- Asserting reset mid-transaction aborts it immediately (asynchronous). No gnt, rvalid or err is produced for the aborted transaction.
- Minimum latency:
  - Request high at cycle 0.
  - `mem_req_o` at cycle 1; with `mem_gnt_i`=1, the requester's gnt is also at cycle 1.
  - Earliest `mem_rvalid_i` and requester rvalid at cycle 2.
  - IDLE at cycle 3, so the next grant decision happens at cycle 3.
- Back-to-back throughput is 1 transaction per 3 cycles minimum.
- `mem_*` outputs are registered. Requester gnt/rvalid/rdata are combinational from `mem_gnt_i` / `mem_rvalid_i` / `mem_rdata_i`.

## Configuration
- **`YARP_MEM_ARB_RR_EN` defined:** round-robin arbitration.
  - A 1-bit pointer records the last granted requester.
  - On simultaneous requests, the requester not granted last wins.
  - The pointer updates when a transaction is latched in IDLE.
- **`YARP_MEM_ARB_RR_EN` undefined:** fixed priority; data always beats instruction. No pointer is implemented.

## Test plan
- **Single instr read.** Stimulus: `imem_req_i`=1, addr 0x1000; mem gnt at cycle 1, rvalid at cycle 2 with 0x00500093. Required: `imem_gnt_o` at cycle 1, `imem_rvalid_o`=1 with rdata 0x00500093 at cycle 2, `busy_o` low at cycle 3.
- **Simultaneous requests, priority.** Stimulus: instr 0x1004 and data write 0x2000 requested at cycle 0. Required (fixed priority): `mem_addr_o`=0x2000, `mem_wr_o`=1 first; instr issued after the data response. Required (RR, last grant = data): instr is issued first.
- **Stalled grant.** Stimulus: `mem_gnt_i` held low for 5 cycles. Required: `mem_req_o` and payload held stable for all 5 cycles; gnt pulses exactly once.
- **Watchdog.** Stimulus: `TIMEOUT_CYC`=4, no `mem_rvalid_i`. Required: `err_o` and `dmem_rvalid_o` pulse with rdata 0 on the 4th WAIT cycle; FSM returns to IDLE.
- **Response and timeout collide.** Stimulus: `mem_rvalid_i` arrives in the same cycle the watchdog expires. Required: data forwarded, `err_o`=0.
- **Reset mid-WAIT and spurious response.** Stimulus: `reset_n` low during WAIT, then released; later, `mem_rvalid_i` pulses while in IDLE. Required: all outputs 0 immediately on reset, state IDLE; the spurious rvalid produces no requester rvalid.
